// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the multiplexed seven-segment display path.
// Holds the digit count, the active-low hex segment patterns (same encoding
// the display driver emits) and the capture FSM state type.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0011000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // Table indexed by nibble value: entry k is the pattern for hex digit k
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
    SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
    SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
    SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational reverse lookup of an active-low segment pattern
// into a hex nibble. Patterns outside the hex table give nibble 0 and assert
// invalid_o.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       invalid_o
);

  logic [15:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign hit[gi] = (seg_i == SEG_HEX_TABLE[gi]);
    end
  endgenerate

  // Table entries are unique, so at most one hit bit is ever set
  always_comb begin
    nibble_o  = 4'h0;
    invalid_o = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (hit[k]) begin
        nibble_o  = 4'(k);
        invalid_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_mux_capture.sv
// seg_mux_capture: snoops a multiplexed 8-digit active-low seven-segment bus,
// decodes each stable digit back to a nibble and publishes the 32-bit word
// once every digit position has been seen in a frame.
// Optional build macro SEGCAP_CONFIRM_EN: publish only when a completed frame
// matches the previously completed frame (value and error flags).
module seg_mux_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic [7:0]  an_in,
  input  logic [6:0]  seg_in,
  output logic [31:0] value_out,
  output logic [7:0]  err_out,
  output logic        frame_valid,
  output logic        frame_timeout
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_MAX  = TW'(TIMEOUT_CYCLES);

  logic [7:0]          an_q;
  logic [6:0]          seg_q;
  logic [SW-1:0]       stab_q, stab_d;
  logic [TW-1:0]       tout_q, tout_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [NUM_DIGITS-1:0]   digit_wr;
  logic [31:0]         value_q;
  logic [7:0]          err_q;
  logic                frame_valid_q, frame_timeout_q;
  cap_state_e          state_q, state_d;

  logic [7:0] sel_low;
  logic       one_hot;
  logic       capture_evt, cap_ok;
  logic       timeout_hit;
  logic       publish_go, timeout_go, publish_ok;
  logic [3:0] dec_nibble;
  logic       dec_invalid;

  // Register the display bus once and track how long it has been unchanged
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      stab_q <= '0;
    end else begin
      an_q   <= an_in;
      seg_q  <= seg_in;
      stab_q <= stab_d;
    end
  end

  // Stability counter: restart on any change, saturate once fully stable
  always_comb begin
    stab_d = stab_q;
    if ({an_in, seg_in} != {an_q, seg_q}) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
  end

  // Capture exactly once per stable period; only single-digit selects count
  assign sel_low     = ~an_q;
  assign one_hot     = (sel_low != 8'h00) && ((sel_low & (sel_low - 8'd1)) == 8'h00);
  assign capture_evt = (stab_q == STAB_LAST);
  assign cap_ok      = capture_evt && one_hot;

  seg7_decode u_decode (
    .seg_i     (seg_q),
    .nibble_o  (dec_nibble),
    .invalid_o (dec_invalid)
  );

  // A fresh capture always beats the abandon timer on the same edge
  assign timeout_hit = (state_q == COLLECT) && !cap_ok && (tout_q == TOUT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_wr[gi] = cap_ok & sel_low[gi];
      assign shadow_val_d[4*gi +: 4] = digit_wr[gi] ? dec_nibble : shadow_val_q[4*gi +: 4];
      assign shadow_err_d[gi] = digit_wr[gi] ? dec_invalid
                              : (timeout_hit ? 1'b0 : shadow_err_q[gi]);
    end
  endgenerate

  // Mask clears on publish/abandon first; a same-edge capture then seeds the next frame
  always_comb begin
    mask_d = mask_q;
    if (state_q == PUBLISH || timeout_hit) begin
      mask_d = '0;
    end
    mask_d = mask_d | digit_wr;
  end

  // Abandon timer counts clocks since the last capture while collecting
  always_comb begin
    tout_d = '0;
    if (cap_ok) begin
      tout_d = '0;
    end else if (state_q == COLLECT) begin
      tout_d = (tout_q == TOUT_MAX) ? tout_q : tout_q + 1'b1;
    end
  end

  // Frame collection state: mask, shadow word, timer
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      mask_q       <= '0;
      shadow_val_q <= '0;
      shadow_err_q <= '0;
      tout_q       <= '0;
    end else begin
      mask_q       <= mask_d;
      shadow_val_q <= shadow_val_d;
      shadow_err_q <= shadow_err_d;
      tout_q       <= tout_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; completion is judged on the post-capture mask
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cap_ok) state_d = COLLECT;
      COLLECT: begin
        if (mask_d == '1) begin
          state_d = PUBLISH;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      PUBLISH: state_d = cap_ok ? COLLECT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    publish_go = 1'b0;
    timeout_go = 1'b0;
    if (state_q == PUBLISH) begin
      publish_go = 1'b1;
    end
    if (timeout_hit) begin
      timeout_go = 1'b1;
    end
  end

`ifdef SEGCAP_CONFIRM_EN
  logic        cand_valid_q;
  logic [31:0] cand_value_q;
  logic [7:0]  cand_err_q;

  // Remember each completed frame as the candidate for the next comparison
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      cand_valid_q <= 1'b0;
      cand_value_q <= '0;
      cand_err_q   <= '0;
    end else if (publish_go) begin
      cand_valid_q <= 1'b1;
      cand_value_q <= shadow_val_q;
      cand_err_q   <= shadow_err_q;
    end
  end

  assign publish_ok = publish_go && cand_valid_q &&
                      (cand_value_q == shadow_val_q) && (cand_err_q == shadow_err_q);
`else
  assign publish_ok = publish_go;
`endif

  // Published word and single-cycle status pulses
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      value_q         <= '0;
      err_q           <= '0;
      frame_valid_q   <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      frame_valid_q   <= publish_ok;
      frame_timeout_q <= timeout_go;
      if (publish_ok) begin
        value_q <= shadow_val_q;
        err_q   <= shadow_err_q;
      end
    end
  end

  assign value_out     = value_q;
  assign err_out       = err_q;
  assign frame_valid   = frame_valid_q;
  assign frame_timeout = frame_timeout_q;

endmodule

// File: tb/tb_seg_mux_capture.sv
// tb_seg_mux_capture: directed plus randomized stimulus for seg_mux_capture,
// checked every cycle against an event-level reference model, with literal
// expectations pinning the directed scenarios.
module tb_seg_mux_capture;

  localparam int STABLE = 4;
  localparam int TOUT   = 250;
`ifdef SEGCAP_CONFIRM_EN
  localparam int REPS = 2;
`else
  localparam int REPS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an_in;
  logic [6:0]  seg_in;
  logic [31:0] value_out;
  logic [7:0]  err_out;
  logic        frame_valid;
  logic        frame_timeout;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_tout  = 0;

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  seg_mux_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_fpga      (clk),
    .reset         (reset),
    .an_in         (an_in),
    .seg_in        (seg_in),
    .value_out     (value_out),
    .err_out       (err_out),
    .frame_valid   (frame_valid),
    .frame_timeout (frame_timeout)
  );

  // ---------------- reference model ----------------
  // A digit is captured on the edge after its {an,seg} value has been seen on
  // exactly STABLE consecutive edges. A frame completes when all 8 positions
  // have been captured and is published on the following edge.
  logic [14:0] h_val;
  int          run;
  int          cyc = 0;
  int          last_cap;
  logic [3:0]  sh_nib [8];
  logic [7:0]  sh_err;
  logic [7:0]  seen;
  bit          pub_pend;
  logic [31:0] m_value;
  logic [7:0]  m_err;
  bit          m_valid, m_tout, m_started = 0;
  logic [31:0] snap_v;
  logic [7:0]  lows;
  bit          cap_ok;
  int          dig;
  logic [3:0]  nib;
  logic        bad;
`ifdef SEGCAP_CONFIRM_EN
  bit          cand_v;
  logic [31:0] cand_val;
  logic [7:0]  cand_err;
`endif

  function automatic void hex_lookup(input logic [6:0] p, output logic [3:0] n, output logic b);
    n = 4'h0;
    b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (tbl[k] == p) begin
        n = 4'(k);
        b = 1'b0;
      end
    end
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_started = 1;
    m_valid = 0;
    m_tout  = 0;
    if (reset) begin
      m_value  = 32'h0;
      m_err    = 8'h0;
      seen     = 8'h0;
      sh_err   = 8'h0;
      pub_pend = 0;
      h_val    = {8'hFF, 7'h7F};
      run      = 1;
      last_cap = cyc;
      for (int k = 0; k < 8; k++) sh_nib[k] = 4'h0;
`ifdef SEGCAP_CONFIRM_EN
      cand_v = 0;
`endif
    end else begin
      lows   = ~h_val[14:7];
      cap_ok = (run == STABLE) && ($countones(lows) == 1);
      if (pub_pend) begin
        for (int k = 0; k < 8; k++) snap_v[4*k +: 4] = sh_nib[k];
`ifdef SEGCAP_CONFIRM_EN
        if (cand_v && cand_val == snap_v && cand_err == sh_err) begin
          m_value = snap_v;
          m_err   = sh_err;
          m_valid = 1;
        end
        cand_v   = 1;
        cand_val = snap_v;
        cand_err = sh_err;
`else
        m_value = snap_v;
        m_err   = sh_err;
        m_valid = 1;
`endif
        seen     = 8'h0;
        pub_pend = 0;
      end else if (seen != 8'h0 && !cap_ok && (cyc - last_cap) == TOUT) begin
        m_tout = 1;
        seen   = 8'h0;
        sh_err = 8'h0;
      end
      if (cap_ok) begin
        dig = 0;
        for (int k = 0; k < 8; k++) if (lows[k]) dig = k;
        hex_lookup(h_val[6:0], nib, bad);
        sh_nib[dig] = nib;
        sh_err[dig] = bad;
        seen[dig]   = 1'b1;
        last_cap    = cyc;
        if (seen == 8'hFF) pub_pend = 1;
      end
      if ({an_in, seg_in} == h_val) begin
        if (run < 1000000) run = run + 1;
      end else begin
        h_val = {an_in, seg_in};
        run   = 1;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_started) begin
      checks = checks + 1;
      if (value_out !== m_value || err_out !== m_err ||
          frame_valid !== m_valid || frame_timeout !== m_tout) begin
        errors = errors + 1;
        $display("FAIL model_cmp cycle %0d: got value=%h err=%h fv=%b ft=%b, expected value=%h err=%h fv=%b ft=%b",
                 cyc, value_out, err_out, frame_valid, frame_timeout,
                 m_value, m_err, m_valid, m_tout);
      end
    end
  end

  // Pulse counters for the directed literal checks
  always @(negedge clk) begin
    if (frame_valid === 1'b1) n_valid = n_valid + 1;
    if (frame_timeout === 1'b1) n_tout = n_tout + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int dwell);
    an_in  = an;
    seg_in = seg;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic show(input int idx, input logic [6:0] pat, input int dwell);
    drive(~(8'd1 << idx), pat, dwell);
  endtask

  task automatic blank(input int n);
    drive(8'hFF, 7'h7F, n);
  endtask

  // Show digits 0..7 of w; bad_digit gets an all-off pattern, glitch_digit is
  // preceded by a short-lived wrong pattern
  task automatic show_word(input logic [31:0] w, input int dwell, input int bad_digit, input int glitch_digit);
    logic [3:0] nb;
    for (int d = 0; d < 8; d++) begin
      nb = w[4*d +: 4];
      if (d == glitch_digit) show(d, tbl[8], 3);
      show(d, (d == bad_digit) ? 7'h7F : tbl[nb], dwell);
    end
  endtask

  task automatic frame_and_check(input string name, input logic [31:0] w, input int dwell,
                                 input int bad_digit, input int glitch_digit,
                                 input logic [31:0] exp_v, input logic [7:0] exp_e);
    n_valid = 0;
    n_tout  = 0;
    repeat (REPS) show_word(w, dwell, bad_digit, glitch_digit);
    blank(10);
    $display("frame %s shown: value_out=%h err_out=%h", name, value_out, err_out);
    check_lit({name, "_value"}, value_out, exp_v);
    check_lit({name, "_err"}, 32'(err_out), 32'(exp_e));
    check_lit({name, "_pulses"}, n_valid, 1);
    check_lit({name, "_no_timeout"}, n_tout, 0);
  endtask

  int ord [8];
  int tmp, j, a, b;
  logic [6:0] pat;

  initial begin
    reset  = 1'b1;
    an_in  = 8'hFF;
    seg_in = 7'h7F;
    repeat (3) @(negedge clk);
    check_lit("reset_value", value_out, 32'h0);
    check_lit("reset_err", 32'(err_out), 32'h0);
    check_lit("reset_pulses", {30'h0, frame_valid, frame_timeout}, 32'h0);
    reset = 1'b0;
    blank(10);

    // Basic frame at a slow multiplex rate
    frame_and_check("basic", 32'h12345678, 200, -1, -1, 32'h12345678, 8'h00);

    // Blank and multi-low selects never capture
    n_valid = 0;
    n_tout  = 0;
    drive(8'b11111100, tbl[5], 1000);
    drive(8'hFF, tbl[5], 1000);
    check_lit("ignore_pulses", n_valid + n_tout, 0);
    check_lit("ignore_value", value_out, 32'h12345678);

    // Unlit digit 3 decodes as an invalid pattern
    frame_and_check("baddigit", 32'hFFFFFFFF, 30, 3, -1, 32'hFFFF0FFF, 8'h08);

    // Short glitch on digit 2 must not be stored
    frame_and_check("glitch", 32'h9ABCDEF0, 25, -1, 2, 32'h9ABCDEF0, 8'h00);

    // Partial frame abandoned by the timer
    n_valid = 0;
    n_tout  = 0;
    for (int d = 0; d < 4; d++) show(d, tbl[d+1], 20);
    blank(TOUT + 50);
    check_lit("timeout_pulses", n_tout, 1);
    check_lit("timeout_no_valid", n_valid, 0);
    check_lit("timeout_value", value_out, 32'h9ABCDEF0);
    frame_and_check("after_timeout", 32'hCAFE0123, 20, -1, -1, 32'hCAFE0123, 8'h00);

    // Reset in the middle of a frame
    for (int d = 0; d < 5; d++) show(d, tbl[7], 20);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_lit("midreset_value", value_out, 32'h0);
    check_lit("midreset_err", 32'(err_out), 32'h0);
    reset = 1'b0;
    blank(10);
    frame_and_check("after_reset", 32'h3456211F, 20, -1, -1, 32'h3456211F, 8'h00);

    // Randomized frames: shuffled order, glitches, overwrites, bad patterns,
    // multi-low selects and occasional abandon gaps
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 8; k++) ord[k] = k;
      for (int k = 7; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
      end
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 7) == 0) show(ord[k], 7'($urandom), $urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) show(ord[k], tbl[$urandom_range(0, 15)], $urandom_range(4, 10));
        if ($urandom_range(0, 9) == 0) pat = 7'($urandom);
        else pat = tbl[$urandom_range(0, 15)];
        show(ord[k], pat, $urandom_range(4, 40));
        if ($urandom_range(0, 15) == 0) begin
          a = $urandom_range(0, 7);
          b = (a + $urandom_range(1, 7)) % 8;
          drive(~((8'd1 << a) | (8'd1 << b)), tbl[$urandom_range(0, 15)], $urandom_range(4, 20));
        end
        if (k == 3 && $urandom_range(0, 9) == 0) blank(TOUT + 10);
      end
      $display("random frame %0d done: value_out=%h err_out=%h", f, value_out, err_out);
    end
    blank(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_mux_capture.md
Name: seg_mux_capture

Overview:
- Receive-side counterpart of the multiplexed 8-digit seven-segment driver.
- Samples the active-low anode-enable and segment buses and decodes each digit's segment pattern back to a hex nibble.
- Reassembles the 32-bit displayed word and publishes it once all 8 digits have been seen in a frame.
- Used as an on-chip display snooper/self-check and as the scoreboard front-end in display testbenches.

Parameters:
- STABLE_CYCLES, 4: consecutive clocks AN and SEG must hold unchanged before the digit is sampled (ghost/lag filter); legal range ≥1.
- TIMEOUT_CYCLES, 400000: clocks without a new digit capture, while a frame is partially collected, before the frame is abandoned.

Ports:
- clk_fpga  in  1  system clock
- reset  in  1  synchronous, active-high reset
- an_in  in  8  digit enables, active-low; one-hot-low selects a digit (bit i = digit i, digit 0 = bits [3:0] of word)
- seg_in  in  7  segment lines, active-low, order {g,f,e,d,c,b,a}
- value_out  out  32  last published word, digit i in [4i+3:4i]
- err_out  out  8  per-digit invalid-pattern flags for the published word
- frame_valid  out  1  single-cycle pulse when value_out/err_out update
- frame_timeout  out  1  single-cycle pulse when a partial frame is abandoned

Behaviour:
- Reset, synchronous, active-high: value_out=0, err_out=0, frame_valid=0, frame_timeout=0, capture mask=0, stability counter=0, timeout counter=0, FSM=IDLE. Reset mid-frame discards all partial data.
- Input registering: an_in and seg_in are registered once. The stability counter clears whenever {an,seg} differs from the previous registered value; otherwise it increments, saturating at STABLE_CYCLES.
- Capture event: fires on the single clock where the counter reaches STABLE_CYCLES-1, i.e. the same {an,seg} was seen on STABLE_CYCLES consecutive edges. Fires once per stable period, never again until the inputs change.
- Qualification: a capture requires an_in to be exactly one-hot-low. All-high (blank) and multi-low inputs are ignored with no error.
- Decode: the pattern is decoded with the 16-entry hex table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Any other pattern stores nibble 0 and sets the shadow error bit i.
- Shadow update: on a qualified capture of digit i, write shadow nibble i and shadow error bit i, and set mask bit i. If mask bit i is already set, overwrite the shadow with the newer data; the mask is unchanged.
- FSM:
  - IDLE: on the first qualified capture, go to COLLECT.
  - COLLECT: when the mask becomes 8'hFF, go to PUBLISH. If TIMEOUT_CYCLES elapse since the last capture, clear mask and shadow errors, pulse frame_timeout, and go to IDLE.
  - PUBLISH, 1 cycle: value_out←shadow, err_out←shadow errors, frame_valid=1, mask←0, then go to IDLE.
- Latency: frame_valid is high exactly one clock after the edge that captured the 8th distinct digit.
- Simultaneous events: a capture in the PUBLISH cycle is applied after the mask clear and starts the next frame. A capture on the timeout edge wins: the timeout counter reloads and no timeout is signalled.
- Counter widths: $clog2(param+1). The timeout counter saturates and does not wrap.

Optional Feature:
- Macro: SEGCAP_CONFIRM_EN.
- Defined: a completed frame is published only if it equals the previously completed frame (value and errors). Otherwise it is held as the candidate and frame_valid stays low. The first completed frame after reset is never published. value_out changes only on two consecutive identical frames.
- Undefined: every completed frame is published.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIGITS=8
  - the 16 segment-pattern constants (shared with the driver)
  - the FSM state typedef {IDLE, COLLECT, PUBLISH}
- Sub-module seg7_decode: combinational, 7-bit pattern → 4-bit nibble plus invalid flag.

Test Plan:
- Drive 32'h12345678 multiplexed at 200 clocks/digit, digits 0..7 → one frame_valid pulse; value_out=32'h12345678; err_out=8'h00.
- seg_in=7'b1111111 while digit 3 is enabled, others encode 32'hFFFF_FFFF → value_out=32'hFFFF_0FFF; err_out=8'h08.
- an_in=8'b11111100 and an_in=8'hFF held for 1000 clocks → no capture; mask stays 0; no pulses.
- 3-clock glitch on seg_in with STABLE_CYCLES=4, then a valid digit → glitch pattern never stored; final word correct.
- Capture digits 0..3 then stop, TIMEOUT_CYCLES=50 → frame_timeout pulses 50 clocks after the last capture; value_out unchanged; the next full frame publishes normally.
- Reset asserted after 5 digits, then a full frame of 32'h3456_211F → outputs return to 0 during reset; after it, frame_valid once with value_out=32'h3456211F.
